// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its three neighbours: the pixel-fetch
// logic (disp_*), the CPU bus bridge (cpu_*) and the single-port VRAM (mem_*).
// The arbiter connects through the slave modport. The surrounding logic connects
// through the master modport.
interface vga_vram_arbiter_if #(
    parameter int AW    = 12,
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    // display fetch path
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;

    // CPU write channel
    logic          cpu_wvalid;
    logic [AW-1:0] cpu_waddr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_wready;

    // CPU read channel
    logic          cpu_rvalid;
    logic [AW-1:0] cpu_raddr;
    logic          cpu_rdone;
    logic [DW-1:0] cpu_rdata;

    // VRAM port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // status
    logic [LW-1:0] fifo_level;

    modport slave (
        input  disp_req, disp_addr,
        output disp_rdata, disp_rvalid,
        input  cpu_wvalid, cpu_waddr, cpu_wdata,
        output cpu_wready,
        input  cpu_rvalid, cpu_raddr,
        output cpu_rdone, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output fifo_level
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_rdata, disp_rvalid,
        output cpu_wvalid, cpu_waddr, cpu_wdata,
        input  cpu_wready,
        output cpu_rvalid, cpu_raddr,
        input  cpu_rdone, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  fifo_level
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter. Display fetches always win. CPU writes are buffered
// in a small FIFO and drained in idle slots. A CPU read waits until the FIFO is
// empty, so it always observes every write accepted before (or with) it.
module vga_vram_arbiter #(
    parameter int AW    = 12,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic               pclk,
    input  logic               reset,
    vga_vram_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // ISSUE_WAIT is kept in the encoding but is never entered.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN      = 2'd1,
        ISSUE_WAIT = 2'd2,
        DATA       = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] raddr_reg, raddr_next;

    logic [AW-1:0] fifo_addr_mem [DEPTH];
    logic [DW-1:0] fifo_data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg;

    logic          disp_rvalid_reg;
    logic          cpu_rdone_reg;
    logic [DW-1:0] cpu_rdata_reg;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          grant_cpu_rd;

    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == LW'(DEPTH));

    // Writes are refused while a read is in flight so that the drain always ends.
    assign bus.cpu_wready = !fifo_full && (state_reg == IDLE) && !reset;
    assign push           = bus.cpu_wvalid && bus.cpu_wready;

    assign bus.disp_rdata  = bus.mem_rdata;
    assign bus.disp_rvalid = disp_rvalid_reg;
    assign bus.cpu_rdone   = cpu_rdone_reg;
    assign bus.cpu_rdata   = cpu_rdata_reg;
    assign bus.fifo_level  = level_reg;

    // Per-cycle VRAM grant: display, then the pending CPU read, then the FIFO head.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = bus.disp_addr;
        bus.mem_wdata = fifo_data_mem[rd_ptr_reg];
        pop           = 1'b0;
        grant_cpu_rd  = 1'b0;
        if (!reset) begin
            if (bus.disp_req) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.disp_addr;
            end else if (state_reg == DRAIN && fifo_empty) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = raddr_reg;
                grant_cpu_rd = 1'b1;
            end else if (!fifo_empty) begin
                // pop depends on the registered level, so a fresh push is never popped the same cycle
                bus.mem_en   = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = fifo_addr_mem[rd_ptr_reg];
                pop          = 1'b1;
            end
        end
    end

    // Read FSM next state: latch the request, wait for the drain, then deliver data.
    always_comb begin
        state_next = state_reg;
        raddr_next = raddr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cpu_rvalid) begin
                    raddr_next = bus.cpu_raddr;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (grant_cpu_rd) begin
                    state_next = DATA;
                end
            end
            DATA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage: one write port per slot, selected by the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // capture the CPU write into this slot when it is the tail
            always_ff @(posedge pclk) begin
                if (push && wr_ptr_reg == PW'(gi)) begin
                    fifo_addr_mem[gi] <= bus.cpu_waddr;
                    fifo_data_mem[gi] <= bus.cpu_wdata;
                end
            end
        end
    endgenerate

    // State, pointers, occupancy and registered outputs.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg       <= IDLE;
            raddr_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            disp_rvalid_reg <= 1'b0;
            cpu_rdone_reg   <= 1'b0;
            cpu_rdata_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            raddr_reg  <= raddr_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            disp_rvalid_reg <= bus.disp_req;
            // rdone is high for exactly the cycle spent in DATA
            cpu_rdone_reg   <= grant_cpu_rd;
            if (state_reg == DATA) begin
                cpu_rdata_reg <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Testbench for vga_vram_arbiter: a directed vector table, hand-written corner
// sequences and a randomized run, all checked every cycle against a queue-based
// model of the arbitration rules.
module tb_vga_vram_arbiter;
    localparam int AW = 12, DW = 8, DEPTH = 4, LW = 3;

    logic pclk = 1'b0;
    logic reset;
    always #5 pclk = ~pclk;

    vga_vram_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus();
    vga_vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (.pclk(pclk), .reset(reset), .bus(bus));

    function automatic logic [7:0] vinit(int i);
        if (i == 'h7FF) return 8'h3C;
        return 8'(i * 37 + 5);
    endfunction

    // VRAM: synchronous read, written by whatever the arbiter grants
    logic [7:0] vram [0:4095];
    bit vram_ready = 1'b0;
    always @(posedge pclk) begin
        if (!vram_ready) begin
            for (int i = 0; i < 4096; i++) vram[i] <= vinit(i);
            vram_ready <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= vram[bus.mem_addr];
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [11:0] a; logic [7:0] d; } wr_t;
    wr_t        wq[$];                 // writes accepted but not yet in VRAM
    logic [7:0] committed [0:4095];    // VRAM contents as the rules predict
    bit         m_rd_wait;             // read accepted, not yet issued
    bit         m_rdone;               // this cycle is the read completion cycle
    logic [11:0] m_rd_addr;
    logic [7:0] m_rd_val, m_rdata, m_disp_val;
    bit         m_drv;

    // value a read must return: the newest accepted write to that address
    function automatic logic [7:0] latest(logic [11:0] addr);
        for (int i = wq.size() - 1; i >= 0; i--)
            if (wq[i].a == addr) return wq[i].d;
        return committed[addr];
    endfunction

    logic        snap_en, snap_we, snap_wready, snap_drv, snap_rdone;
    logic [11:0] snap_addr;
    logic [7:0]  snap_wdata, snap_rdata;
    logic [2:0]  snap_level;

    // Inputs are set just after a falling edge; check 2 ns later, advance model, wait for next falling edge.
    task automatic tick();
        bit g_disp, g_rd, g_wr, busy, e_wready;
        #2;
        busy     = m_rd_wait || m_rdone;
        e_wready = !reset && (wq.size() < DEPTH) && !busy;
        g_disp = 0; g_rd = 0; g_wr = 0;
        if (!reset) begin
            if (bus.disp_req)                       g_disp = 1;
            else if (m_rd_wait && wq.size() == 0)   g_rd = 1;
            else if (wq.size() != 0)                g_wr = 1;
        end
        chk("mem_en", bus.mem_en, g_disp | g_rd | g_wr);
        if (g_disp | g_rd | g_wr) begin
            chk("mem_we", bus.mem_we, g_wr);
            chk("mem_addr", bus.mem_addr, g_disp ? bus.disp_addr : (g_rd ? m_rd_addr : wq[0].a));
            if (g_wr) chk("mem_wdata", bus.mem_wdata, wq[0].d);
        end
        chk("cpu_wready", bus.cpu_wready, e_wready);
        chk("fifo_level", bus.fifo_level, wq.size());
        chk("disp_rvalid", bus.disp_rvalid, m_drv);
        if (m_drv) chk("disp_rdata", bus.disp_rdata, m_disp_val);
        chk("cpu_rdone", bus.cpu_rdone, m_rdone);
        chk("cpu_rdata", bus.cpu_rdata, m_rdata);

        snap_en = bus.mem_en; snap_we = bus.mem_we; snap_addr = bus.mem_addr;
        snap_wdata = bus.mem_wdata; snap_wready = bus.cpu_wready; snap_level = bus.fifo_level;
        snap_drv = bus.disp_rvalid; snap_rdone = bus.cpu_rdone; snap_rdata = bus.cpu_rdata;

        if (reset) begin
            wq.delete(); m_rd_wait = 0; m_rdone = 0; m_rdata = '0; m_drv = 0;
        end else begin
            if (m_rdone) begin m_rdata = m_rd_val; m_rdone = 0; end
            if (g_disp) m_disp_val = committed[bus.disp_addr];
            if (g_rd) begin m_rd_wait = 0; m_rdone = 1; end
            if (g_wr) begin committed[wq[0].a] = wq[0].d; void'(wq.pop_front()); end
            if (bus.cpu_wvalid && e_wready) wq.push_back(wr_t'{bus.cpu_waddr, bus.cpu_wdata});
            if (bus.cpu_rvalid && !busy) begin
                m_rd_wait = 1; m_rd_addr = bus.cpu_raddr; m_rd_val = latest(bus.cpu_raddr);
            end
            m_drv = bus.disp_req;
        end
        @(negedge pclk);
    endtask

    task automatic idle_inputs();
        bus.disp_req = 0; bus.disp_addr = '0;
        bus.cpu_wvalid = 0; bus.cpu_waddr = '0; bus.cpu_wdata = '0;
        bus.cpu_rvalid = 0; bus.cpu_raddr = '0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit dreq; logic [11:0] daddr;
        bit wv;   logic [11:0] wa; logic [7:0] wd;
        bit rv;   logic [11:0] ra;
        bit e_en; bit e_we; logic [11:0] e_addr; logic [7:0] e_wdata;
        bit e_wready; int e_level; bit e_drv; bit e_rdone; logic [7:0] e_rdata;
    } vec_t;
    vec_t tv [14];

    initial begin
        int cnt, wcyc, rcyc, got;
        wr_t seen[$];

        tv[0]  = '{0,12'h000, 0,12'h000,8'h00, 1,12'h7FF, 0,0,12'h000,8'h00, 1,0, 0,0, 8'h00};
        tv[1]  = '{0,12'h000, 0,12'h000,8'h00, 1,12'h7FF, 1,0,12'h7FF,8'h00, 0,0, 0,0, 8'h00};
        tv[2]  = '{0,12'h000, 0,12'h000,8'h00, 1,12'h7FF, 0,0,12'h000,8'h00, 0,0, 0,1, 8'h00};
        tv[3]  = '{0,12'h000, 0,12'h000,8'h00, 0,12'h000, 0,0,12'h000,8'h00, 1,0, 0,0, 8'h3C};
        tv[4]  = '{1,12'h100, 0,12'h000,8'h00, 0,12'h000, 1,0,12'h100,8'h00, 1,0, 0,0, 8'h3C};
        tv[5]  = '{1,12'h101, 1,12'h010,8'hA0, 0,12'h000, 1,0,12'h101,8'h00, 1,0, 1,0, 8'h3C};
        tv[6]  = '{0,12'h000, 1,12'h011,8'hA1, 0,12'h000, 1,1,12'h010,8'hA0, 1,1, 1,0, 8'h3C};
        tv[7]  = '{0,12'h000, 0,12'h000,8'h00, 0,12'h000, 1,1,12'h011,8'hA1, 1,1, 0,0, 8'h3C};
        tv[8]  = '{0,12'h000, 0,12'h000,8'h00, 0,12'h000, 0,0,12'h000,8'h00, 1,0, 0,0, 8'h3C};
        tv[9]  = '{0,12'h000, 1,12'h020,8'h77, 1,12'h010, 0,0,12'h000,8'h00, 1,0, 0,0, 8'h3C};
        tv[10] = '{0,12'h000, 0,12'h000,8'h00, 1,12'h010, 1,1,12'h020,8'h77, 0,1, 0,0, 8'h3C};
        tv[11] = '{0,12'h000, 0,12'h000,8'h00, 1,12'h010, 1,0,12'h010,8'h00, 0,0, 0,0, 8'h3C};
        tv[12] = '{0,12'h000, 0,12'h000,8'h00, 1,12'h010, 0,0,12'h000,8'h00, 0,0, 0,1, 8'h3C};
        tv[13] = '{0,12'h000, 0,12'h000,8'h00, 0,12'h000, 0,0,12'h000,8'h00, 1,0, 0,0, 8'hA0};

        for (int i = 0; i < 4096; i++) committed[i] = vinit(i);
        wq.delete(); m_rd_wait = 0; m_rdone = 0; m_rdata = '0; m_drv = 0;
        m_rd_addr = '0; m_rd_val = '0; m_disp_val = '0;
        reset = 1; idle_inputs();
        @(negedge pclk);
        for (int k = 0; k < 3; k++) tick();
        reset = 0;

        // table: best-case read, display latency, push/pop, RAW across addresses
        for (int i = 0; i < 14; i++) begin
            bus.disp_req = tv[i].dreq; bus.disp_addr = tv[i].daddr;
            bus.cpu_wvalid = tv[i].wv; bus.cpu_waddr = tv[i].wa; bus.cpu_wdata = tv[i].wd;
            bus.cpu_rvalid = tv[i].rv; bus.cpu_raddr = tv[i].ra;
            tick();
            chk($sformatf("vec%0d.mem_en", i), snap_en, tv[i].e_en);
            if (tv[i].e_en) begin
                chk($sformatf("vec%0d.mem_we", i), snap_we, tv[i].e_we);
                chk($sformatf("vec%0d.mem_addr", i), snap_addr, tv[i].e_addr);
                if (tv[i].e_we) chk($sformatf("vec%0d.mem_wdata", i), snap_wdata, tv[i].e_wdata);
            end
            chk($sformatf("vec%0d.wready", i), snap_wready, tv[i].e_wready);
            chk($sformatf("vec%0d.level", i), snap_level, tv[i].e_level);
            chk($sformatf("vec%0d.disp_rvalid", i), snap_drv, tv[i].e_drv);
            chk($sformatf("vec%0d.rdone", i), snap_rdone, tv[i].e_rdone);
            chk($sformatf("vec%0d.rdata", i), snap_rdata, tv[i].e_rdata);
            $display("vec %0d applied: en=%0b we=%0b addr=%03h level=%0d", i, snap_en, snap_we, snap_addr, snap_level);
        end

        // reset during a pending read with 3 buffered writes
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            bus.disp_req = 1; bus.disp_addr = 12'(12'h500 + k);
            bus.cpu_wvalid = 1; bus.cpu_waddr = 12'(12'h200 + k); bus.cpu_wdata = 8'(8'hC0 + k);
            tick();
        end
        bus.cpu_wvalid = 0; bus.cpu_rvalid = 1; bus.cpu_raddr = 12'h200;
        tick(); tick();
        reset = 1;
        for (int k = 0; k < 2; k++) begin tick(); chk("rst_mem_en", snap_en, 0); chk("rst_wready", snap_wready, 0); end
        reset = 0; idle_inputs(); cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) chk("rst_level", snap_level, 0);
            cnt += int'(snap_rdone);
        end
        chk("rst_no_rdone", cnt, 0);
        $display("reset sequence done: rdone pulses=%0d", cnt);

        // display priority with 4 queued writes
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            bus.disp_req = 1; bus.disp_addr = 12'(12'h300 + k);
            bus.cpu_wvalid = (k < 4); bus.cpu_waddr = 12'(12'h010 + k); bus.cpu_wdata = 8'(8'hA0 + k);
            tick();
            cnt += int'(snap_en && snap_we);
        end
        chk("disp_no_we", cnt, 0);
        chk("disp_level", snap_level, 4);
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("disp_drain_we", snap_en && snap_we, 1);
            chk("disp_drain_addr", snap_addr, 12'h010 + k);
            chk("disp_drain_data", snap_wdata, 8'hA0 + k);
            chk("disp_rvalid_trail", snap_drv, k == 0);
        end
        $display("display priority sequence done");

        // FIFO full with display held, then drain
        seen.delete();
        for (int k = 0; k < 5; k++) begin
            bus.disp_req = 1; bus.cpu_wvalid = 1;
            bus.cpu_waddr = 12'(12'h400 + k); bus.cpu_wdata = 8'(8'h50 + k);
            tick();
            if (k == 4) begin chk("full_wready", snap_wready, 0); chk("full_level", snap_level, 4); end
            else chk("fill_wready", snap_wready, 1);
        end
        bus.disp_req = 0;
        got = 0;
        for (int k = 0; k < 20 && seen.size() < 5; k++) begin
            tick();
            if (snap_en && snap_we) seen.push_back(wr_t'{snap_addr, snap_wdata});
            if (bus.cpu_wvalid && snap_wready) begin got = 1; bus.cpu_wvalid = 0; end
        end
        chk("full_5th_accepted", got, 1);
        chk("full_write_count", seen.size(), 5);
        for (int k = 0; k < seen.size() && k < 5; k++) begin
            chk("full_order_addr", seen[k].a, 12'h400 + k);
            chk("full_order_data", seen[k].d, 8'h50 + k);
        end
        idle_inputs(); tick(); tick();
        $display("fifo full sequence done: writes seen=%0d", seen.size());

        // RAW: write and read of the same address in one cycle
        bus.cpu_wvalid = 1; bus.cpu_waddr = 12'h123; bus.cpu_wdata = 8'h55;
        bus.cpu_rvalid = 1; bus.cpu_raddr = 12'h123;
        wcyc = -1; rcyc = -1; cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            bus.cpu_wvalid = 0;
            if (snap_en && snap_we && snap_addr == 12'h123 && wcyc < 0) wcyc = k;
            if (snap_en && !snap_we && snap_addr == 12'h123 && rcyc < 0) rcyc = k;
            if (snap_rdone) begin cnt++; bus.cpu_rvalid = 0; end
        end
        chk("raw_rdone_once", cnt, 1);
        chk("raw_write_seen", wcyc >= 0, 1);
        chk("raw_write_first", wcyc < rcyc, 1);
        chk("raw_rdata", snap_rdata, 8'h55);
        $display("raw sequence done: write cycle %0d read cycle %0d", wcyc, rcyc);

        // read blocked by 3 cycles of display traffic
        idle_inputs();
        bus.cpu_rvalid = 1; bus.cpu_raddr = 12'h7FF;
        rcyc = -1;
        for (int k = 0; k < 15 && rcyc < 0; k++) begin
            bus.disp_req = (k >= 1 && k <= 3); bus.disp_addr = 12'(12'h600 + k);
            tick();
            if (k >= 1) chk("blk_wready", snap_wready, 0);
            if (snap_rdone) rcyc = k;
        end
        chk("blk_latency", rcyc, 5);
        idle_inputs(); tick();
        chk("blk_rdata", snap_rdata, 8'h3C);
        $display("blocked read sequence done: rdone after %0d cycles", rcyc);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.disp_req = ($urandom_range(0, 99) < 35);
            bus.disp_addr = 12'($urandom_range(0, 4095));
            bus.cpu_wvalid = 1'($urandom_range(0, 1));
            bus.cpu_waddr = 12'($urandom_range(0, 15));
            bus.cpu_wdata = 8'($urandom);
            if (!(m_rd_wait || m_rdone)) begin
                bus.cpu_rvalid = ($urandom_range(0, 3) == 0);
                bus.cpu_raddr = 12'($urandom_range(0, 15));
            end
            tick();
        end
        reset = 0; idle_inputs(); tick();
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
